// File: rtl/stoch_arith_unit_if.sv
// Control/result bundle for stoch_arith_unit: start/operands in, busy/done/count out.
// Macro STOCH_CONT_EN adds the cont line for self-restarting windows.
interface stoch_arith_unit_if #(
  parameter int PROB_W   = 4,
  parameter int WIN_LOG2 = 3
);
  logic              start;
  logic [1:0]        mode;
  logic [PROB_W-1:0] prob_a;
  logic [PROB_W-1:0] prob_b;
  logic [PROB_W-1:0] prob_sel;
  logic              busy;
  logic              done;
  logic [WIN_LOG2:0] count;
  logic              sn_out;

`ifdef STOCH_CONT_EN
  logic              cont;

  modport master (output start, mode, prob_a, prob_b, prob_sel, cont,
                  input  busy, done, count, sn_out);
  modport slave  (input  start, mode, prob_a, prob_b, prob_sel, cont,
                  output busy, done, count, sn_out);
`else
  modport master (output start, mode, prob_a, prob_b, prob_sel,
                  input  busy, done, count, sn_out);
  modport slave  (input  start, mode, prob_a, prob_b, prob_sel,
                  output busy, done, count, sn_out);
`endif
endinterface

// File: rtl/stoch_arith_unit.sv
// Stochastic arithmetic unit: three free-running LFSR streams, MUX/AND/XNOR/pass
// combiner and a 2^WIN_LOG2-cycle ones counter. Macro STOCH_CONT_EN enables bus.cont.
module stoch_arith_unit #(
  parameter int          PROB_W   = 4,
  parameter int          WIN_LOG2 = 3,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2,
  parameter logic [30:0] SEED_S   = 31'd3
) (
  input  logic              clk,
  input  logic              rst_n,
  stoch_arith_unit_if.slave bus
);
  localparam int                N          = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] PRIME_LAST = (WIN_LOG2 + 1)'(1);
  localparam logic [WIN_LOG2:0] RUN_LAST   = (WIN_LOG2 + 1)'(N - 1);
  localparam logic [30:0]       SEED_A_EFF = (SEED_A == 31'd0) ? 31'd1 : SEED_A;
  localparam logic [30:0]       SEED_B_EFF = (SEED_B == 31'd0) ? 31'd1 : SEED_B;
  localparam logic [30:0]       SEED_S_EFF = (SEED_S == 31'd0) ? 31'd1 : SEED_S;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t            state_q;
  logic [WIN_LOG2:0] phase_q;
  logic [WIN_LOG2:0] acc_q;
  logic [WIN_LOG2:0] count_q;
  logic              busy_q;
  logic              done_q;
  logic              sn_q;
  logic              sn_d;
  logic [1:0]        mode_q;
  logic [PROB_W-1:0] prob_q [3];
  logic [2:0]        cmp_w;
  logic              restart_w;
  logic              accept_w;

  // Lane 0 = operand A, lane 1 = operand B, lane 2 = MUX select.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam logic [30:0] SEED = (gi == 0) ? SEED_A_EFF :
                                   (gi == 1) ? SEED_B_EFF : SEED_S_EFF;
    logic [30:0] lfsr_q;
    logic        cmp_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lfsr_q <= SEED;
        cmp_q  <= 1'b0;
      end else begin
        lfsr_q <= {lfsr_q[29:0], lfsr_q[27] ^ lfsr_q[30]};
        cmp_q  <= (lfsr_q[PROB_W-1:0] < prob_q[gi]);
      end
    end

    assign cmp_w[gi] = cmp_q;
  end

`ifdef STOCH_CONT_EN
  assign restart_w = bus.start | bus.cont;
`else
  assign restart_w = bus.start;
`endif

  assign accept_w = ((state_q == IDLE) && bus.start) || ((state_q == DONE) && restart_w);

  always_comb begin
    sn_d = cmp_w[0];
    case (mode_q)
      2'b00:   sn_d = cmp_w[2] ? cmp_w[1] : cmp_w[0];
      2'b01:   sn_d = cmp_w[0] & cmp_w[1];
      2'b10:   sn_d = ~(cmp_w[0] ^ cmp_w[1]);
      default: sn_d = cmp_w[0];
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sn_q    <= 1'b0;
      mode_q  <= 2'b00;
      for (int i = 0; i < 3; i++) prob_q[i] <= '0;
    end else begin
      sn_q   <= sn_d;
      busy_q <= (state_q == PRIME) || (state_q == RUN);
      done_q <= (state_q == DONE);
      if (accept_w) begin
        mode_q    <= bus.mode;
        prob_q[0] <= bus.prob_a;
        prob_q[1] <= bus.prob_b;
        prob_q[2] <= bus.prob_sel;
      end
      case (state_q)
        IDLE: begin
          phase_q <= '0;
          if (accept_w) state_q <= PRIME;
        end
        PRIME: begin
          acc_q <= '0;
          if (phase_q == PRIME_LAST) begin
            phase_q <= '0;
            state_q <= RUN;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_q + {{WIN_LOG2{1'b0}}, sn_q};
          if (phase_q == RUN_LAST) state_q <= DONE;
          else                     phase_q <= phase_q + 1'b1;
        end
        DONE: begin
          count_q <= acc_q;
          phase_q <= '0;
          state_q <= accept_w ? PRIME : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.count  = count_q;
  assign bus.sn_out = sn_q;
endmodule

// File: tb/tb_stoch_arith_unit.sv
// Scoreboard bench for stoch_arith_unit: each accepted start queues the window expected
// from an LFSR sequence model indexed by clock edges since reset; a monitor scores it.
module tb_stoch_arith_unit;
  localparam int PROB_W   = 4;
  localparam int WIN_LOG2 = 3;
  localparam int N        = 1 << WIN_LOG2;
  localparam int HIST     = 4096;
  localparam int PMAX     = (1 << PROB_W) - 1;

  typedef struct {
    int                k;
    logic [1:0]        mode;
    logic [PROB_W-1:0] pa;
    logic [PROB_W-1:0] pb;
    logic [PROB_W-1:0] ps;
    int                cnt;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int edge_n    = 0;
  int next_free = 0;
  int exp_count = 0;

  txn_t txq[$];
  txn_t snq[$];
  txn_t snops;
  logic [30:0] la [HIST];
  logic [30:0] lb [HIST];
  logic [30:0] ls [HIST];

  always #5 clk = ~clk;

  stoch_arith_unit_if #(.PROB_W(PROB_W), .WIN_LOG2(WIN_LOG2)) bus();

  stoch_arith_unit #(
    .PROB_W(PROB_W), .WIN_LOG2(WIN_LOG2),
    .SEED_A(31'd1), .SEED_B(31'd2), .SEED_S(31'd3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Edges since the last reset release; value j means the LFSRs hold la[j] etc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n = 0;
    else        edge_n = edge_n + 1;
  end

  function automatic logic [30:0] lfsr_next(logic [30:0] v);
    return {v[29:0], v[27] ^ v[30]};
  endfunction

  function automatic bit model_bit(txn_t t, int j);
    logic [30:0] va, vb, vs;
    bit a, b, s;
    va = la[j];
    vb = lb[j];
    vs = ls[j];
    a = (va[PROB_W-1:0] < t.pa);
    b = (vb[PROB_W-1:0] < t.pb);
    s = (vs[PROB_W-1:0] < t.ps);
    case (t.mode)
      2'b00:   return s ? b : a;
      2'b01:   return a && b;
      2'b10:   return a == b;
      default: return a;
    endcase
  endfunction

  function automatic int model_count(txn_t t);
    int n = 0;
    for (int j = t.k; j < t.k + N; j++) n += int'(model_bit(t, j));
    return n;
  endfunction

  function automatic txn_t zero_txn();
    txn_t t;
    t.k = 0; t.mode = 2'b00; t.pa = '0; t.pb = '0; t.ps = '0; t.cnt = 0;
    return t;
  endfunction

  function automatic logic [PROB_W-1:0] rnd_prob();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return PROB_W'(PMAX);
      default: return PROB_W'($urandom_range(0, PMAX));
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle before the sampling edge with start already driven high.
  task automatic push_txn();
    txn_t t;
    t.k    = edge_n + 1;
    t.mode = bus.mode;
    t.pa   = bus.prob_a;
    t.pb   = bus.prob_b;
    t.ps   = bus.prob_sel;
    t.cnt  = model_count(t);
    txq.push_back(t);
    snq.push_back(t);
    next_free = t.k + N + 4;
    $display("txn k=%0d mode=%0d pa=%0d pb=%0d ps=%0d expect count=%0d",
             t.k, t.mode, t.pa, t.pb, t.ps, t.cnt);
  endtask

  task automatic issue(logic [1:0] m, logic [PROB_W-1:0] pa, logic [PROB_W-1:0] pb,
                       logic [PROB_W-1:0] ps, int gap);
    repeat (gap) step();
    while (edge_n + 1 < next_free) step();
    bus.mode     = m;
    bus.prob_a   = pa;
    bus.prob_b   = pb;
    bus.prob_sel = ps;
    bus.start    = 1'b1;
    push_txn();
    step();
    bus.start = 1'b0;
  endtask

  task automatic burst(int n_txn);
    while (edge_n + 1 < next_free) step();
    bus.mode = 2'($urandom_range(0, 3));
    bus.prob_a = rnd_prob(); bus.prob_b = rnd_prob(); bus.prob_sel = rnd_prob();
    bus.start = 1'b1;
    push_txn();
    for (int i = 1; i < n_txn; i++) begin
      step();
      bus.mode = 2'($urandom_range(0, 3));
      bus.prob_a = rnd_prob(); bus.prob_b = rnd_prob(); bus.prob_sel = rnd_prob();
      repeat (N + 2) step();
      push_txn();
    end
    step();
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    txn_t t;
    int   e;
    bit   due;
    bit   busy_exp;
    if (!rst_n) begin
      chk("rst_busy",  int'(bus.busy),   0);
      chk("rst_done",  int'(bus.done),   0);
      chk("rst_count", int'(bus.count),  0);
      chk("rst_sn",    int'(bus.sn_out), 0);
    end else begin
      e = edge_n;
      busy_exp = (txq.size() > 0) && (e >= txq[0].k + 1) && (e <= txq[0].k + N + 2);
      chk("busy", int'(bus.busy), int'(busy_exp));
      due = (txq.size() > 0) && (e == txq[0].k + N + 3);
      if (bus.done || due) begin
        if (txq.size() == 0) begin
          chk("done_unexpected", int'(bus.done), 0);
        end else begin
          t = txq.pop_front();
          chk("done_latency", e, t.k + N + 3);
          chk("done_pulse", int'(bus.done), 1);
          chk("result", int'(bus.count), t.cnt);
          exp_count = t.cnt;
        end
      end
      chk("count_hold", int'(bus.count), exp_count);
      while (snq.size() > 0 && snq[0].k <= e - 2) snops = snq.pop_front();
      // The cycle right after a latch mixes new mode with old comparator bits.
      if (!(snq.size() > 0 && snq[0].k == e - 1))
        chk("sn_out", int'(bus.sn_out), (e >= 2) ? int'(model_bit(snops, e - 2)) : 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [PROB_W-1:0] pb0;
    la[0] = 31'd1;
    lb[0] = 31'd2;
    ls[0] = 31'd3;
    for (int i = 1; i < HIST; i++) begin
      la[i] = lfsr_next(la[i-1]);
      lb[i] = lfsr_next(lb[i-1]);
      ls[i] = lfsr_next(ls[i-1]);
    end
    snops        = zero_txn();
    bus.start    = 1'b0;
    bus.mode     = 2'b00;
    bus.prob_a   = '0;
    bus.prob_b   = '0;
    bus.prob_sel = '0;
`ifdef STOCH_CONT_EN
    bus.cont     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First window after power-up; replayed after the mid-window reset below.
    pb0 = PROB_W'($urandom_range(0, PMAX));
    issue(2'b00, PROB_W'(8), pb0, '0, 1);

    issue(2'b11, '0, rnd_prob(), rnd_prob(), 0);
    issue(2'b01, PROB_W'(PMAX), '0, rnd_prob(), 2);
    issue(2'b10, PROB_W'(PMAX), '0, rnd_prob(), 0);

    // A start pulse in the middle of RUN must be ignored.
    issue(2'($urandom_range(0, 3)), rnd_prob(), rnd_prob(), rnd_prob(), 0);
    repeat (4) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;

    burst(4);

    for (int i = 0; i < 16; i++) begin
      issue(2'($urandom_range(0, 3)), rnd_prob(), rnd_prob(), rnd_prob(),
            int'($urandom_range(0, 3)));
      bus.prob_a   = rnd_prob();
      bus.prob_b   = rnd_prob();
      bus.prob_sel = rnd_prob();
      bus.mode     = 2'($urandom_range(0, 3));
    end

    // Abort a window with an asynchronous reset between clock edges.
    issue(2'($urandom_range(0, 3)), rnd_prob(), rnd_prob(), rnd_prob(), 0);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    txq.delete();
    snq.delete();
    snops     = zero_txn();
    exp_count = 0;
    next_free = 0;
    #1;
    chk("async_rst_busy",  int'(bus.busy),   0);
    chk("async_rst_done",  int'(bus.done),   0);
    chk("async_rst_count", int'(bus.count),  0);
    chk("async_rst_sn",    int'(bus.sn_out), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(2'b00, PROB_W'(8), pb0, '0, 1);

    burst(2);
    issue(2'($urandom_range(0, 3)), rnd_prob(), rnd_prob(), rnd_prob(), 1);

    repeat (N + 6) step();
    chk("drain", txq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
